prog_loader: RTL and testbench

Byte-stream program loader: the write-side counterpart of the 14-bit × 2048-word program memory the core fetches from. Accepts a framed byte stream over a valid/ready handshake, assembles 14-bit instruction words, and writes them to program RAM at consecutive addresses from 0. Holds the CPU in reset until a complete image has been written.

---
 rtl/prog_loader.sv | 228 ++++++++++++++++++++++
 tb/tb_prog_loader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader that writes 14-bit words into the 2048-word program RAM
// and holds the CPU in reset until a complete image is in place. Optional checksum byte: PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        Pram_we,
    output logic [10:0] Pram_addr,
    output logic [13:0] Pram_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    // state    | meaning
    // IDLE     | after reset, waiting for the sync byte
    // CNT_HI   | waiting for word-count high byte
    // CNT_LO   | waiting for word-count low byte
    // W_HI     | waiting for instruction high byte
    // W_LO     | waiting for instruction low byte
    // WRITE    | one-cycle RAM write strobe, input stalled
    // CHK      | waiting for checksum byte (checksum builds only)
    // DONE     | image loaded, CPU released; sync restarts
    // ERR      | frame error, CPU held; sync restarts
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_CNT_HI = 4'd1;
    localparam logic [3:0] S_CNT_LO = 4'd2;
    localparam logic [3:0] S_W_HI   = 4'd3;
    localparam logic [3:0] S_W_LO   = 4'd4;
    localparam logic [3:0] S_WRITE  = 4'd5;
    localparam logic [3:0] S_DONE   = 4'd6;
    localparam logic [3:0] S_ERR    = 4'd7;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam logic [3:0] S_CHK    = 4'd8;
`endif

    logic [3:0]  state_q, state_d;
    logic [10:0] addr_q, addr_d;
    logic [13:0] data_q, data_d;
    logic        we_q, we_d;
    logic [10:0] remain_q, remain_d;
    logic [2:0]  cnt_hi_q, cnt_hi_d;
    logic [5:0]  w_hi_q, w_hi_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        hold_q, hold_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  csum_sum;
`endif

    logic        accept;
    logic        is_sync;
    logic        goto_tail;
    logic [10:0] n_words;

    assign accept   = in_valid && (state_q != S_WRITE);
    assign is_sync  = (in_data == SYNC_BYTE);
    assign n_words  = {cnt_hi_q, in_data};
`ifdef PROG_LOADER_CHECKSUM_EN
    assign csum_sum = csum_q + in_data;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        we_d      = 1'b0;
        remain_d  = remain_q;
        cnt_hi_d  = cnt_hi_q;
        w_hi_d    = w_hi_q;
        done_d    = done_q;
        err_d     = err_q;
        hold_d    = hold_q;
        goto_tail = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (accept && is_sync) begin
                    state_d = S_CNT_HI;
                    addr_d  = 11'd0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d  = 8'd0;
`endif
                end
            end
            S_CNT_HI: begin
                if (accept) begin
                    cnt_hi_d = in_data[2:0];
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d   = csum_sum;
`endif
                    if (in_data[7:3] != 5'd0) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_CNT_LO;
                    end
                end
            end
            S_CNT_LO: begin
                if (accept) begin
                    remain_d = n_words;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d   = csum_sum;
`endif
                    if (n_words != 11'd0) begin
                        state_d = S_W_HI;
                    end else begin
                        goto_tail = 1'b1;
                    end
                end
            end
            S_W_HI: begin
                if (accept) begin
                    w_hi_d = in_data[5:0];
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d = csum_sum;
`endif
                    if (in_data[7:6] != 2'd0) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_W_LO;
                    end
                end
            end
            S_W_LO: begin
                if (accept) begin
                    data_d  = {w_hi_q, in_data};
                    we_d    = 1'b1;
                    state_d = S_WRITE;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d  = csum_sum;
`endif
                end
            end
            S_WRITE: begin
                // remain_q counts words still to write including this one
                addr_d   = addr_q + 11'd1;
                remain_d = remain_q - 11'd1;
                if (remain_q == 11'd1) begin
                    goto_tail = 1'b1;
                end else begin
                    state_d = S_W_HI;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    if (csum_sum == 8'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (goto_tail) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= 11'd0;
            data_q   <= 14'd0;
            we_q     <= 1'b0;
            remain_q <= 11'd0;
            cnt_hi_q <= 3'd0;
            w_hi_q   <= 6'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            hold_q   <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q   <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_q     <= we_d;
            remain_q <= remain_d;
            cnt_hi_q <= cnt_hi_d;
            w_hi_q   <= w_hi_d;
            done_q   <= done_d;
            err_q    <= err_d;
            hold_q   <= hold_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign in_ready  = (state_q != S_WRITE);
    assign Pram_we   = we_q;
    assign Pram_addr = addr_q;
    assign Pram_data = data_q;
    assign cpu_hold  = hold_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed-vector bench for prog_loader; covers the default build and, when
// PROG_LOADER_CHECKSUM_EN is defined, the trailing checksum byte.
module tb_prog_loader;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        Pram_we;
    logic [10:0] Pram_addr;
    logic [13:0] Pram_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int checks;
    int failures;
    int cycle_cnt;
    int ready_viol;
    logic [10:0] wr_addr[$];
    logic [13:0] wr_data[$];

    prog_loader #(.SYNC_BYTE(8'hA5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .Pram_we   (Pram_we),
        .Pram_addr (Pram_addr),
        .Pram_data (Pram_data),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Write monitor: logs every RAM write and flags any cycle where in_ready is not the inverse of the strobe.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (Pram_we === 1'b1) begin
                wr_addr.push_back(Pram_addr);
                wr_data.push_back(Pram_data);
            end
            if (in_ready === Pram_we) ready_viol <= ready_viol + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 8) begin
            checks++; failures++;
            $display("FAIL send_timeout: in_ready=%b still low, required 1 for byte %h", in_ready, b);
        end
        @(negedge clk);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (2) @(negedge clk);
        checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL reset_hold: got %b required 1", cpu_hold); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b required 0", done); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b required 0", err); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b required 1", in_ready); end
        checks++; if (Pram_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b required 0", Pram_we); end
        checks++; if (Pram_addr !== 11'd0) begin failures++; $display("FAIL reset_addr: got %h required 0", Pram_addr); end
        checks++; if (Pram_data !== 14'd0) begin failures++; $display("FAIL reset_data: got %h required 0", Pram_data); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        clear_log();
        send_byte(8'hA5);
        checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL basic_hold_start: got %b required 1", cpu_hold); end
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h30);
        send_byte(8'h04);
        checks++; if (Pram_we !== 1'b1) begin failures++; $display("FAIL basic_we0: got %b required 1", Pram_we); end
        checks++; if (Pram_addr !== 11'd0) begin failures++; $display("FAIL basic_addr0: got %h required 0", Pram_addr); end
        checks++; if (Pram_data !== 14'h3004) begin failures++; $display("FAIL basic_data0: got %h required 3004", Pram_data); end
        send_byte(8'h00);
        send_byte(8'hA5);
        checks++; if (Pram_addr !== 11'd1) begin failures++; $display("FAIL basic_addr1: got %h required 1", Pram_addr); end
        checks++; if (Pram_data !== 14'h00A5) begin failures++; $display("FAIL basic_data1: got %h required 00a5", Pram_data); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_early: got %b required 0", done); end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h25);
        in_valid = 1'b0;
`else
        in_valid = 1'b0;
        @(negedge clk);
`endif
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done: got %b required 1", done); end
        checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL basic_hold_end: got %b required 0", cpu_hold); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL basic_err: got %b required 0", err); end
        checks++; if (wr_addr.size() != 2) begin failures++; $display("FAIL basic_wr_count: got %0d required 2", wr_addr.size()); end
    endtask

    task automatic test_junk_idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log();
        send_byte(8'h12);
        send_byte(8'h34);
        checks++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL junk_ignored: got hold=%b done=%b required hold=1 done=0", cpu_hold, done); end
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        in_valid = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL empty_done: got %b required 1", done); end
        checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL empty_hold: got %b required 0", cpu_hold); end
        repeat (2) @(negedge clk);
        checks++; if (wr_addr.size() != 0) begin failures++; $display("FAIL empty_no_writes: got %0d required 0", wr_addr.size()); end
    endtask

    task automatic test_err_count();
        clear_log();
        send_byte(8'hA5);
        checks++; if (err !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL cnterr_clear: got err=%b done=%b required 0 0", err, done); end
        send_byte(8'h08);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL cnterr_err: got %b required 1", err); end
        checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL cnterr_hold: got %b required 1", cpu_hold); end
        send_byte(8'h00);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL cnterr_sticky: got %b required 1", err); end
        send_byte(8'hA5);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL cnterr_restart: got %b required 0", err); end
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h28);
        send_byte(8'h10);
        checks++; if (Pram_we !== 1'b1 || Pram_addr !== 11'd0 || Pram_data !== 14'h2810) begin failures++; $display("FAIL cnterr_write: got we=%b addr=%h data=%h required 1 000 2810", Pram_we, Pram_addr, Pram_data); end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'hC7);
        in_valid = 1'b0;
`else
        in_valid = 1'b0;
        @(negedge clk);
`endif
        checks++; if (done !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL cnterr_done: got done=%b err=%b required 1 0", done, err); end
    endtask

    task automatic test_err_word();
        clear_log();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hC0);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL wordhi_err: got %b required 1", err); end
        send_byte(8'h00);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (wr_addr.size() != 0) begin failures++; $display("FAIL wordhi_no_write: got %0d required 0", wr_addr.size()); end
        checks++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL wordhi_hold: got hold=%b done=%b required 1 0", cpu_hold, done); end
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_checksum_bad();
        clear_log();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h30);
        send_byte(8'h04);
        send_byte(8'h00);
        in_valid = 1'b0;
        checks++; if (err !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL chk_err: got err=%b done=%b required 1 0", err, done); end
        checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL chk_hold: got %b required 1", cpu_hold); end
        checks++; if (wr_addr.size() != 1) begin failures++; $display("FAIL chk_kept_write: got %0d required 1", wr_addr.size()); end
    endtask
`endif

    task automatic test_back_to_back();
        int c0;
        int exp_cycles;
`ifdef PROG_LOADER_CHECKSUM_EN
        exp_cycles = 10;
`else
        exp_cycles = 9;
`endif
        clear_log();
        ready_viol = 0;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h03);
        c0 = cycle_cnt;
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h02);
        send_byte(8'h22);
        send_byte(8'h03);
        send_byte(8'h33);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h91);
`endif
        for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
        in_valid = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done: got %b required 1", done); end
        checks++; if (cycle_cnt - c0 != exp_cycles) begin failures++; $display("FAIL b2b_cycles: got %0d required %0d", cycle_cnt - c0, exp_cycles); end
        checks++; if (ready_viol != 0) begin failures++; $display("FAIL b2b_ready: got %0d bad cycles required 0", ready_viol); end
        checks++; if (wr_addr.size() != 3) begin failures++; $display("FAIL b2b_count: got %0d required 3", wr_addr.size()); end
        if (wr_addr.size() == 3) begin
            checks++; if (wr_addr[0] !== 11'd0 || wr_addr[1] !== 11'd1 || wr_addr[2] !== 11'd2) begin failures++; $display("FAIL b2b_addr: got %h %h %h required 0 1 2", wr_addr[0], wr_addr[1], wr_addr[2]); end
            checks++; if (wr_data[0] !== 14'h0111 || wr_data[1] !== 14'h0222 || wr_data[2] !== 14'h0333) begin failures++; $display("FAIL b2b_data: got %h %h %h required 0111 0222 0333", wr_data[0], wr_data[1], wr_data[2]); end
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h30);
        send_byte(8'h04);
        send_byte(8'h11);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (Pram_addr !== 11'd0) begin failures++; $display("FAIL rstmid_addr: got %h required 0", Pram_addr); end
        checks++; if (Pram_data !== 14'd0 || Pram_we !== 1'b0) begin failures++; $display("FAIL rstmid_data: got data=%h we=%b required 0 0", Pram_data, Pram_we); end
        checks++; if (cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ctrl: got hold=%b done=%b err=%b rdy=%b required 1 0 0 1", cpu_hold, done, err, in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h05);
        send_byte(8'h06);
        checks++; if (Pram_we !== 1'b1 || Pram_addr !== 11'd0 || Pram_data !== 14'h0506) begin failures++; $display("FAIL rstmid_fresh: got we=%b addr=%h data=%h required 1 000 0506", Pram_we, Pram_addr, Pram_data); end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'hF4);
        in_valid = 1'b0;
`else
        in_valid = 1'b0;
        @(negedge clk);
`endif
        checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin failures++; $display("FAIL rstmid_done: got done=%b hold=%b required 1 0", done, cpu_hold); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cycle_cnt = 0;
        ready_viol = 0;
        test_reset();
        test_basic_frame();
        test_junk_idle();
        test_err_count();
        test_err_word();
`ifdef PROG_LOADER_CHECKSUM_EN
        test_checksum_bad();
`endif
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
